result_collector: RTL and testbench

//  Downstream stage of the 3x3 matrix-multiply controller. During the readout phase each
//  of the 9 results leaves memout as 3 part beats (part 0,1,2), one beat per cycle, with no

---
 rtl/result_collector.sv | 175 +++++++++++++++++
 tb/tb_result_collector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// rtl/result_collector.sv - reassembles 3-part memout beats into results and streams them from a FIFO
//
// Purpose: during a readout frame, collects part beats 0,1,2 of each result into one
//          3*PART_W word, pushes {data, idx, last} into a show-ahead FIFO, presents the
//          head on a valid/ready stream and pulses frame_done after the last result pops.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begins a new frame (flushes FIFO, clears flags and counters)
//   part_valid/part_idx/part_addr/part_data   incoming part beat
//   res_valid/res_ready      result stream handshake
//   res_data/res_idx/res_last  head entry {part2,part1,part0}, result index, last-of-frame
//   frame_done               1-cycle pulse after the last result is consumed
//   seq_err, ovf             sticky error flags, cleared by start or rst

module result_collector #(
    parameter int PART_W = 8,
    parameter int N_RES  = 9,
    parameter int DEPTH  = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                part_valid,
    input  logic [1:0]          part_idx,
    input  logic [4:0]          part_addr,
    input  logic [PART_W-1:0]   part_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [3*PART_W-1:0] res_data,
    output logic [3:0]          res_idx,
    output logic                res_last,
    output logic                frame_done,
    output logic                seq_err,
    output logic                ovf
);

    localparam int RES_W = 3 * PART_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PCW   = $clog2(N_RES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [RES_W-1:0] mem_data [DEPTH];
    logic [3:0]       mem_idx  [DEPTH];
    logic             mem_last [DEPTH];

    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [PCW-1:0]   push_cnt;
    logic [1:0]       exp_part;
    logic [RES_W-1:0] asm_data;
    logic [3:0]       asm_idx;

    logic collecting, in_seq, good_beat, bad_beat;
    logic push, push_last, full, pop, wr_en, head_last, frame_done_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // start wins over a same-cycle beat, so the beat is not even considered.
    assign collecting = (state == S_COLLECT) && part_valid && !start;
    // exp_part never holds 3, so part_idx==3 always lands in bad_beat.
    assign in_seq     = (part_idx == exp_part);
    assign good_beat  = collecting && in_seq;
    assign bad_beat   = collecting && !in_seq;
    assign push       = good_beat && (part_idx == 2'd2);
    assign push_last  = (push_cnt == PCW'(N_RES - 1));
    assign full       = (count == CW'(DEPTH));
    assign res_valid  = (count != '0);
    assign pop        = res_valid && res_ready && !start;
    // When full, a write is only safe if the head slot is leaving this same cycle.
    assign wr_en      = push && (!full || pop);
    assign head_last  = mem_last[rd_ptr];

    assign res_data   = res_valid ? mem_data[rd_ptr] : '0;
    assign res_idx    = res_valid ? mem_idx[rd_ptr]  : '0;
    assign res_last   = res_valid && head_last;

    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        if (start) begin
            state_nxt = S_COLLECT;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_IDLE;
                S_COLLECT: if (push && push_last) state_nxt = S_FLUSH;
                S_FLUSH: begin
                    if (pop && head_last) begin
                        state_nxt      = S_IDLE;
                        frame_done_nxt = 1'b1;
                    end
                end
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= {part_data, asm_data[2*PART_W-1:0]};
            mem_idx[wr_ptr]  <= asm_idx;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            push_cnt <= '0;
            exp_part <= 2'd0;
            asm_data <= '0;
            asm_idx  <= '0;
            seq_err  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (good_beat) begin
                case (part_idx)
                    2'd0: begin
                        asm_data[0 +: PART_W] <= part_data;
                        asm_idx               <= part_addr[3:0];
                    end
                    2'd1:    asm_data[PART_W +: PART_W] <= part_data;
                    default: asm_data[2*PART_W +: PART_W] <= part_data;
                endcase
                exp_part <= (part_idx == 2'd2) ? 2'd0 : exp_part + 2'd1;
            end else if (bad_beat) begin
                seq_err <= 1'b1;
                if (part_idx == 2'd0) begin
                    asm_data <= {{(2*PART_W){1'b0}}, part_data};
                    asm_idx  <= part_addr[3:0];
                    exp_part <= 2'd1;
                end else begin
                    asm_data <= '0;
                    exp_part <= 2'd0;
                end
            end

            // A dropped push still counts toward the frame so the FSM reaches FLUSH.
            if (push) begin
                push_cnt <= push_cnt + 1'b1;
                if (full && !pop) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - self-checking bench for result_collector (DEPTH 9 and DEPTH 4 builds)

module tb_result_collector;

    logic        clk = 1'b0;
    logic        rst, start, pv, rr, rr4;
    logic [1:0]  pi;
    logic [4:0]  pa;
    logic [7:0]  pd;

    logic        res_valid, res_last, frame_done, seq_err, ovf;
    logic [23:0] res_data;
    logic [3:0]  res_idx;
    logic        res_valid4, res_last4, frame_done4, seq_err4, ovf4;
    logic [23:0] res_data4;
    logic [3:0]  res_idx4;

    always #5 clk = ~clk;

    result_collector #(.PART_W(8), .N_RES(9), .DEPTH(9)) dut (
        .clk(clk), .rst(rst), .start(start), .part_valid(pv), .part_idx(pi),
        .part_addr(pa), .part_data(pd), .res_valid(res_valid), .res_ready(rr),
        .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
        .frame_done(frame_done), .seq_err(seq_err), .ovf(ovf)
    );

    result_collector #(.PART_W(8), .N_RES(9), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .part_valid(pv), .part_idx(pi),
        .part_addr(pa), .part_data(pd), .res_valid(res_valid4), .res_ready(rr4),
        .res_data(res_data4), .res_idx(res_idx4), .res_last(res_last4),
        .frame_done(frame_done4), .seq_err(seq_err4), .ovf(ovf4)
    );

    typedef struct packed {
        logic [23:0] d;
        logic [3:0]  idx;
        logic        last;
    } ent_t;

    // Reference model of the DEPTH=9 instance: a queue of results plus frame bookkeeping.
    ent_t       q[$];
    int         m_state;   // 0 idle, 1 collecting, 2 waiting for last pop
    int         m_exp, m_pcnt;
    logic [7:0] m_p0, m_p1;
    logic [3:0] m_addr;
    logic       m_seq, m_ovf, m_fd;

    int nassert = 0;
    int nfail   = 0;
    int fd_cnt, obs_pops;
    bit rand_rr;
    logic [23:0] e4 [7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        nassert++;
        assert (got === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic check_outputs();
        chk("res_valid", {31'd0, res_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("res_data", {8'd0, res_data}, {8'd0, q[0].d});
            chk("res_idx",  {28'd0, res_idx}, {28'd0, q[0].idx});
            chk("res_last", {31'd0, res_last}, {31'd0, q[0].last});
        end
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
        chk("seq_err",    {31'd0, seq_err},    {31'd0, m_seq});
        chk("ovf",        {31'd0, ovf},        {31'd0, m_ovf});
        if (frame_done === 1'b1) fd_cnt++;
        if (res_valid === 1'b1 && rr) obs_pops++;
    endtask

    task automatic model_tick();
        bit pop, plast, full, nfd;
        if (rst) begin
            q.delete();
            m_state = 0; m_exp = 0; m_pcnt = 0;
            m_seq = 0; m_ovf = 0; m_fd = 0;
        end else if (start) begin
            q.delete();
            m_state = 1; m_exp = 0; m_pcnt = 0;
            m_seq = 0; m_ovf = 0; m_fd = 0;
        end else begin
            pop   = (q.size() != 0) && rr;
            plast = pop && q[0].last;
            full  = (q.size() == 9);
            nfd   = (m_state == 2) && plast;
            if (pop) void'(q.pop_front());
            if (m_state == 2 && plast) begin
                m_state = 0;
            end else if (m_state == 1 && pv) begin
                if (int'(pi) == m_exp) begin
                    if (pi == 2'd0) begin m_p0 = pd; m_addr = pa[3:0]; end
                    if (pi == 2'd1) m_p1 = pd;
                    if (pi == 2'd2) begin
                        if (full && !pop) m_ovf = 1;
                        else q.push_back('{d: {pd, m_p1, m_p0}, idx: m_addr, last: (m_pcnt == 8)});
                        m_pcnt++;
                        m_exp = 0;
                        if (m_pcnt == 9) m_state = 2;
                    end else begin
                        m_exp++;
                    end
                end else begin
                    m_seq = 1;
                    if (pi == 2'd0) begin m_p0 = pd; m_addr = pa[3:0]; m_exp = 1; end
                    else m_exp = 0;
                end
            end
            m_fd = nfd;
        end
    endtask

    task automatic step(input bit st, input bit v, input int i, input int a, input int d);
        check_outputs();
        start = st; pv = v; pi = i[1:0]; pa = a[4:0]; pd = d[7:0];
        model_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input int i, input int a, input int d);
        if (rand_rr) rr = 1'($urandom_range(0, 1));
        step(0, 1, i, a, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic frame(input bit seq_data);
        for (int r = 0; r < 9; r++)
            for (int p = 0; p < 3; p++)
                beat(p, r, seq_data ? (r * 3 + p) : int'($urandom_range(0, 255)));
    endtask

    initial begin
        rst = 1; start = 0; pv = 0; pi = 0; pa = 0; pd = 0; rr = 0; rr4 = 0; rand_rr = 0;
        model_tick();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data",  {8'd0, res_data},   32'd0);
        chk("rst_flags", {29'd0, frame_done, seq_err, ovf}, 32'd0);

        // 1: sequential-data frame, always ready
        fd_cnt = 0; rr = 1;
        step(1, 0, 0, 0, 0);
        beat(0, 0, 0); beat(1, 0, 1); beat(2, 0, 2);
        chk("t1_first_valid", {31'd0, res_valid}, 32'd1);
        chk("t1_first_data",  {8'd0, res_data},   32'h020100);
        chk("t1_first_idx",   {28'd0, res_idx},   32'd0);
        for (int r = 1; r < 9; r++)
            for (int p = 0; p < 3; p++) beat(p, r, r * 3 + p);
        idle(6);
        chk("t1_frame_done_cnt", fd_cnt, 1);

        // 2: whole frame buffered with no consumer, then drained
        rr = 0;
        step(1, 0, 0, 0, 0);
        frame(0);
        idle(2);
        chk("t2_ovf", {31'd0, ovf}, 32'd0);
        chk("t2_model_full", q.size(), 9);
        rr = 1; obs_pops = 0; fd_cnt = 0;
        idle(12);
        chk("t2_pops", obs_pops, 9);
        chk("t2_frame_done_cnt", fd_cnt, 1);

        // 3: sequence errors, then random beats
        rr = 0;
        step(1, 0, 0, 0, 0);
        beat(0, 0, 8'h11); beat(2, 0, 8'h22);
        chk("t3_seq_err", {31'd0, seq_err}, 32'd1);
        chk("t3_no_push", {31'd0, res_valid}, 32'd0);
        beat(0, 5, 8'hA0); beat(1, 5, 8'hA1); beat(2, 5, 8'hA2);
        chk("t3_push_idx",  {28'd0, res_idx}, 32'd5);
        chk("t3_push_data", {8'd0, res_data}, 32'hA2A1A0);
        for (int k = 0; k < 80; k++) begin
            rr = 1'($urandom_range(0, 1));
            step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
        end
        chk("t3_seq_sticky", {31'd0, seq_err}, 32'd1);

        // 4: DEPTH=4 instance overflow and push+pop at full
        rr = 0; rr4 = 0;
        step(1, 0, 0, 0, 0);
        for (int r = 0; r < 7; r++) begin
            logic [7:0] b0, b1, b2;
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            e4[r] = {b2, b1, b0};
            if (r == 6) begin
                chk("t4_valid_full", {31'd0, res_valid4}, 32'd1);
                chk("t4_ovf", {31'd0, ovf4}, 32'd1);
                chk("t4_head0", {8'd0, res_data4}, {8'd0, e4[0]});
            end
            beat(0, r, b0); beat(1, r, b1);
            if (r == 6) rr4 = 1;
            beat(2, r, b2);
            rr4 = 0;
        end
        chk("t4_head_after_pp", {8'd0, res_data4}, {8'd0, e4[1]});
        rr4 = 1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_drain", {8'd0, res_data4}, {8'd0, e4[(k == 3) ? 6 : k + 1]});
            idle(1);
        end
        chk("t4_empty", {31'd0, res_valid4}, 32'd0);
        rr4 = 0;

        // 5: restart mid-collect, then a fresh frame with random backpressure
        rr = 0;
        step(1, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++)
            for (int p = 0; p < 3; p++) beat(p, r, int'($urandom_range(0, 255)));
        step(1, 0, 0, 0, 0);
        chk("t5_flushed", {31'd0, res_valid}, 32'd0);
        chk("t5_flags", {30'd0, seq_err, ovf}, 32'd0);
        obs_pops = 0; rand_rr = 1;
        frame(0);
        rand_rr = 0; rr = 1;
        idle(12);
        chk("t5_pops", obs_pops, 9);

        // 6: reset during the flush phase
        rr = 0;
        step(1, 0, 0, 0, 0);
        frame(0);
        rr = 1;
        idle(2);
        rr = 0; rst = 1;
        idle(1);
        rst = 0;
        chk("t6_valid", {31'd0, res_valid}, 32'd0);
        chk("t6_data",  {8'd0, res_data},   32'd0);
        chk("t6_idx_last", {27'd0, res_idx, res_last}, 32'd0);
        chk("t6_flags", {29'd0, frame_done, seq_err, ovf}, 32'd0);
        for (int p = 0; p < 6; p++) beat(p % 3, 1, 8'h5A);
        chk("t6_ignored", {31'd0, res_valid}, 32'd0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
